// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the transmit FIFO and serialises them as
// start / DATA_BITS data (LSB first) / optional parity / stop-bit frames.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | line high, waiting for enable and a non-empty FIFO
// POP    | pop issued, FIFO updating Data_Out
// LOAD   | latch Tx_Data and its parity
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), high
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 FIFO_Empty,
  input  logic                 Tx_Enable,
  input  logic                 BIST_Mode,
  output logic                 Pop_Data,
  output logic                 Tx_Serial,
  output logic                 Tx_Busy,
  output logic                 Tx_Done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t               state, state_nxt;
  logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 parity, parity_nxt;
  logic                 pop_nxt, serial_nxt, busy_nxt, done_nxt;
  logic                 bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      Pop_Data  <= 1'b0;
      Tx_Serial <= 1'b1;
      Tx_Busy   <= 1'b0;
      Tx_Done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      parity    <= parity_nxt;
      Pop_Data  <= pop_nxt;
      Tx_Serial <= serial_nxt;
      Tx_Busy   <= busy_nxt;
      Tx_Done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift_reg;
    parity_nxt = parity;
    pop_nxt    = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (Tx_Enable && !FIFO_Empty && !BIST_Mode) begin
          state_nxt = POP;
          pop_nxt   = 1'b1;
        end
      end
      POP: state_nxt = LOAD;
      LOAD: begin
        shift_nxt  = Tx_Data;
        parity_nxt = (^Tx_Data) ^ PAR_ODD;
        baud_nxt   = '0;
        bit_nxt    = '0;
        state_nxt  = START;
      end
      START: begin
        baud_nxt = bit_end ? '0 : baud_cnt + BAUD_ONE;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        baud_nxt = bit_end ? '0 : baud_cnt + BAUD_ONE;
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_ONE;
          end
        end
      end
      PARITY: begin
        baud_nxt = bit_end ? '0 : baud_cnt + BAUD_ONE;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        baud_nxt = bit_end ? '0 : baud_cnt + BAUD_ONE;
        // bit_cnt doubles as the stop-bit counter
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + BIT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Serial level is registered from the state being entered
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      PARITY:  serial_nxt = parity_nxt;
      default: serial_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a FIFO model feeds an 8N1 instance, two
// single-shot instances cover even and odd parity; frames compared to a bit-list model.
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: 8N1 fed by FIFO model
  logic [7:0] f0_data = 8'h00;
  logic       f0_empty = 1'b1;
  logic       tx_en0 = 1'b1, bist0 = 1'b0;
  logic       pop0, ser0, busy0, done0;
  // instances 1 (even parity) and 2 (odd parity): single-shot driven
  logic [7:0] d1_data = 8'h00, d2_data = 8'h00;
  logic       d1_empty = 1'b1, d2_empty = 1'b1;
  logic       en12 = 1'b1, bist12 = 1'b0;
  logic       pop1, ser1, busy1, done1;
  logic       pop2, ser2, busy2, done2;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .Tx_Data(f0_data), .FIFO_Empty(f0_empty),
    .Tx_Enable(tx_en0), .BIST_Mode(bist0), .Pop_Data(pop0), .Tx_Serial(ser0),
    .Tx_Busy(busy0), .Tx_Done(done0));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Tx_Data(d1_data), .FIFO_Empty(d1_empty),
    .Tx_Enable(en12), .BIST_Mode(bist12), .Pop_Data(pop1), .Tx_Serial(ser1),
    .Tx_Busy(busy1), .Tx_Done(done1));

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .Tx_Data(d2_data), .FIFO_Empty(d2_empty),
    .Tx_Enable(en12), .BIST_Mode(bist12), .Pop_Data(pop2), .Tx_Serial(ser2),
    .Tx_Busy(busy2), .Tx_Done(done2));

  int n_checks = 0;
  int n_err = 0;

  // FIFO model: Data_Out shows the popped entry on the edge after Pop_Data
  logic [7:0] q0[$];
  int underflow0 = 0;
  int pop0_cnt = 0;
  int done0_cnt = 0;

  always @(posedge clk) begin
    if (pop0) begin
      if (q0.size() > 0) begin
        f0_data <= q0[0];
        q0.pop_front();
      end else begin
        underflow0 <= underflow0 + 1;
      end
    end
    f0_empty <= (q0.size() == 0);
  end

  always @(negedge clk) begin
    if (pop0)  pop0_cnt  <= pop0_cnt + 1;
    if (done0) done0_cnt <= done0_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic ser_of(input int i);
    case (i)
      0: return ser0;
      1: return ser1;
      default: return ser2;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(input int i);
    case (i)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic pop_of(input int i);
    case (i)
      0: return pop0;
      1: return pop1;
      default: return pop2;
    endcase
  endfunction

  // Reference: frame is a list of bits, each held CPB cycles
  function automatic logic model_bit(input logic [7:0] d, input bit pen, input bit podd, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (pen && j == 9) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int idx, output int n);
    n = 0;
    while (ser_of(idx) !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("start_bit_seen", ser_of(idx), 1'b0);
  endtask

  // Called on the first start-bit sample; returns samples until Tx_Done
  task automatic capture(input int idx, output int len, output logic [0:95] s, output int busy_bad);
    s = '0;
    s[0] = ser_of(idx);
    busy_bad = busy_of(idx) ? 0 : 1;
    len = -1;
    for (int k = 1; k < 90; k++) begin
      @(negedge clk);
      if (done_of(idx)) begin
        len = k;
        if (busy_of(idx)) busy_bad++;
        break;
      end
      s[k] = ser_of(idx);
      if (!busy_of(idx)) busy_bad++;
    end
  endtask

  task automatic check_frame(input int idx, input logic [7:0] d, input bit pen, input bit podd,
                             input string tag, output logic par_obs, output logic [0:95] s);
    int len, bb, nb, bad;
    capture(idx, len, s, bb);
    nb = 10 + (pen ? 1 : 0);
    chk({tag, "_len"}, len, nb * CPB);
    bad = 0;
    for (int k = 0; k < nb * CPB; k++)
      if (s[k] !== model_bit(d, pen, podd, k / CPB)) bad++;
    chk({tag, "_bits"}, bad, 0);
    chk({tag, "_busy"}, bb, 0);
    par_obs = s[9 * CPB + CPB / 2];
  endtask

  task automatic send_single(input int idx, input logic [7:0] d);
    int n;
    bit seen;
    @(negedge clk);
    if (idx == 1) begin d1_data = d; d1_empty = 1'b0; end
    else begin d2_data = d; d2_empty = 1'b0; end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = pop_of(idx);
    end
    d1_empty = 1'b1;
    d2_empty = 1'b1;
    chk("single_pop_seen", seen, 1'b1);
    @(negedge clk);
    chk("pop_single_cycle", pop_of(idx), 1'b0);
    wait_start(idx, n);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       exp_par;
  } par_vec_t;

  par_vec_t pv[6];

  initial begin
    int n, bad, exp_pops, exp_dones;
    logic par;
    logic [0:95] s;
    logic [0:9] ref_a5;
    logic [7:0] rb, r1, r2;

    pv[0] = '{1, 8'hA5, 1'b0};
    pv[1] = '{1, 8'h07, 1'b1};
    pv[2] = '{2, 8'h07, 1'b0};
    pv[3] = '{2, 8'hA5, 1'b1};
    pv[4] = '{1, 8'h00, 1'b0};
    pv[5] = '{2, 8'hFF, 1'b1};
    exp_pops = 0;
    exp_dones = 0;

    // Reset values on all instances
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_serial", ser_of(i), 1'b1);
      chk("rst_busy",   busy_of(i), 1'b0);
      chk("rst_pop",    pop_of(i), 1'b0);
      chk("rst_done",   done_of(i), 1'b0);
    end
    rst_n = 1'b1;

    // Idle with empty FIFO for 100 cycles
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (ser_of(i) !== 1'b1 || pop_of(i) !== 1'b0 || busy_of(i) !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    // 8N1 0xA5
    q0.push_back(8'hA5);
    wait_start(0, n);
    chk("a5_start_latency", n, 4);
    check_frame(0, 8'hA5, 0, 0, "a5", par, s);
    exp_pops++; exp_dones++;
    ref_a5 = 10'b0101001011;
    bad = 0;
    for (int j = 0; j < 10; j++)
      if (s[j * CPB + 2] !== ref_a5[j]) bad++;
    chk("a5_stream", bad, 0);
    repeat (10) @(negedge clk);
    chk("a5_pops", pop0_cnt, exp_pops);
    chk("a5_dones", done0_cnt, exp_dones);
    chk("a5_idle_busy", busy0, 1'b0);

    // Parity table
    for (int i = 0; i < 6; i++) begin
      send_single(pv[i].dut, pv[i].data);
      check_frame(pv[i].dut, pv[i].data, 1, pv[i].dut == 2, "par", par, s);
      chk("par_bit", par, pv[i].exp_par);
    end

    // Back-to-back 0x01, 0x80, 0xFF
    @(negedge clk);
    q0.push_back(8'h01); q0.push_back(8'h80); q0.push_back(8'hFF);
    wait_start(0, n);
    check_frame(0, 8'h01, 0, 0, "b2b0", par, s);
    wait_start(0, n);
    chk("b2b_gap1", n, 3);
    check_frame(0, 8'h80, 0, 0, "b2b1", par, s);
    wait_start(0, n);
    chk("b2b_gap2", n, 3);
    check_frame(0, 8'hFF, 0, 0, "b2b2", par, s);
    exp_pops += 3; exp_dones += 3;
    repeat (10) @(negedge clk);
    chk("b2b_pops", pop0_cnt, exp_pops);
    chk("b2b_dones", done0_cnt, exp_dones);

    // Random back-to-back on the 8N1 instance
    for (int i = 0; i < 6; i++) q0.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      rb = q0[0];
      wait_start(0, n);
      if (i > 0) chk("rnd_gap", n, 3);
      check_frame(0, rb, 0, 0, "rnd", par, s);
    end
    exp_pops += 6; exp_dones += 6;

    // Random parity frames
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      send_single(1 + (i % 2), rb);
      check_frame(1 + (i % 2), rb, 1, (i % 2) == 1, "rnd_par", par, s);
    end

    // Gating by Tx_Enable, then by BIST_Mode
    for (int g = 0; g < 2; g++) begin
      r1 = 8'($urandom); r2 = 8'($urandom);
      @(negedge clk);
      q0.push_back(r1); q0.push_back(r2);
      wait_start(0, n);
      fork
        check_frame(0, r1, 0, 0, "gate_a", par, s);
        begin
          repeat (12) @(negedge clk);
          if (g == 0) tx_en0 = 1'b0; else bist0 = 1'b1;
        end
      join
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (pop0 !== 1'b0 || busy0 !== 1'b0) bad++;
      end
      chk("gate_hold", bad, 0);
      tx_en0 = 1'b1; bist0 = 1'b0;
      @(negedge clk);
      chk("gate_release_pop", pop0, 1'b1);
      wait_start(0, n);
      check_frame(0, r2, 0, 0, "gate_b", par, s);
      exp_pops += 2; exp_dones += 2;
    end

    // Reset during data bit 3
    r2 = 8'($urandom);
    @(negedge clk);
    q0.push_back(8'hF0); q0.push_back(r2);
    wait_start(0, n);
    repeat (CPB * 4 + 1) @(negedge clk);
    chk("mid_pre_rst_bit3", ser0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", ser0, 1'b1);
    chk("mid_rst_busy", busy0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(0, n);
    chk("mid_rst_restart", n, 3);
    check_frame(0, r2, 0, 0, "after_rst", par, s);
    exp_pops += 2; exp_dones += 1;

    repeat (5) @(negedge clk);
    chk("total_pops", pop0_cnt, exp_pops);
    chk("total_dones", done0_cnt, exp_dones);
    chk("fifo_underflow", underflow0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
